// File: rtl/tail_light_pkg.sv
// Shared types and constants for the rear light bank sequencer.
// Holds the state encoding, mode codes, lamp patterns and the output pattern function.
package tail_light_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_L1, S_L2, S_L3, S_L4, S_R1, S_R2, S_R3, S_R4, S_HZ_ON, S_HZ_OFF
  } state_e;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_e;

  typedef enum logic {SIDE_LEFT = 1'b0, SIDE_RIGHT = 1'b1} side_e;

  localparam logic [3:0] LEFT_PAT  [1:4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
  localparam logic [3:0] RIGHT_PAT [1:4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
  localparam logic [7:0] LEFT_MASK  = 8'hF0;
  localparam logic [7:0] RIGHT_MASK = 8'h0F;

  function automatic mode_e mode_of(input state_e s);
    case (s)
      S_L1, S_L2, S_L3, S_L4:  return MODE_LEFT;
      S_R1, S_R2, S_R3, S_R4:  return MODE_RIGHT;
      S_HZ_ON, S_HZ_OFF:       return MODE_HAZARD;
      default:                 return MODE_IDLE;
    endcase
  endfunction

  // Banks outside the owned mask are lit by brake; hazard owns both banks so brake has no effect.
  function automatic logic [7:0] pattern_of(input state_e s, input logic brake);
    logic [7:0] pat;
    logic [7:0] owned;
    pat   = 8'h00;
    owned = 8'h00;
    case (s)
      S_L1:     begin pat = {LEFT_PAT[1], 4'h0};  owned = LEFT_MASK;  end
      S_L2:     begin pat = {LEFT_PAT[2], 4'h0};  owned = LEFT_MASK;  end
      S_L3:     begin pat = {LEFT_PAT[3], 4'h0};  owned = LEFT_MASK;  end
      S_L4:     begin pat = {LEFT_PAT[4], 4'h0};  owned = LEFT_MASK;  end
      S_R1:     begin pat = {4'h0, RIGHT_PAT[1]}; owned = RIGHT_MASK; end
      S_R2:     begin pat = {4'h0, RIGHT_PAT[2]}; owned = RIGHT_MASK; end
      S_R3:     begin pat = {4'h0, RIGHT_PAT[3]}; owned = RIGHT_MASK; end
      S_R4:     begin pat = {4'h0, RIGHT_PAT[4]}; owned = RIGHT_MASK; end
      S_HZ_ON:  begin pat = 8'hFF;                owned = 8'hFF;      end
      S_HZ_OFF: begin pat = 8'h00;                owned = 8'hFF;      end
      default:  begin pat = 8'h00;                owned = 8'h00;      end
    endcase
    return brake ? (pat | ~owned) : pat;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step prescaler: one-cycle tick every TICK_DIV clk cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/tail_light_scheduler.sv
// Shares the 8-lamp rear bank among left/right turn, hazard and brake.
// Sticky turn latches, priority + round-robin arbiter, step FSM, registered lamp outputs.
module tail_light_scheduler
  import tail_light_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  input  logic       brake,
  output logic [7:0] leds,
  output logic [1:0] mode,
  output logic       busy,
  output logic       seq_done
);

  state_e state, next_state;
  side_e  last_grant;
  mode_e  mode_q;
  logic   tick;
  logic   pend_l, pend_r;
  logic   grant_l, grant_r, enter_hz, done_d;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    grant_l    = 1'b0;
    grant_r    = 1'b0;
    done_d     = 1'b0;
    if (tick) begin
      if (hazard_req && state != S_HZ_ON && state != S_HZ_OFF) begin
        next_state = S_HZ_ON;
      end else begin
        case (state)
          S_IDLE: begin
            // On a tie, the side opposite the last grant wins.
            if (pend_l && (!pend_r || last_grant == SIDE_RIGHT)) begin
              next_state = S_L1;
              grant_l    = 1'b1;
            end else if (pend_r) begin
              next_state = S_R1;
              grant_r    = 1'b1;
            end
          end
          S_L1:     next_state = S_L2;
          S_L2:     next_state = S_L3;
          S_L3:     next_state = S_L4;
          S_L4:     begin next_state = S_IDLE; done_d = 1'b1; end
          S_R1:     next_state = S_R2;
          S_R2:     next_state = S_R3;
          S_R3:     next_state = S_R4;
          S_R4:     begin next_state = S_IDLE; done_d = 1'b1; end
          S_HZ_ON:  next_state = S_HZ_OFF;
          S_HZ_OFF: next_state = hazard_req ? S_HZ_ON : S_IDLE;
          default:  next_state = S_IDLE;
        endcase
      end
    end
    enter_hz = (next_state == S_HZ_ON) && (state != S_HZ_ON);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pend_l     <= 1'b0;
      pend_r     <= 1'b0;
      last_grant <= SIDE_RIGHT;
      leds       <= 8'h00;
      mode_q     <= MODE_IDLE;
      busy       <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      state  <= next_state;
      // Clearing beats a same-cycle set, so a held request re-arms one cycle after its grant.
      pend_l <= (pend_l | left_req)  & ~(grant_l | enter_hz);
      pend_r <= (pend_r | right_req) & ~(grant_r | enter_hz);
      if (grant_l)      last_grant <= SIDE_LEFT;
      else if (grant_r) last_grant <= SIDE_RIGHT;
      leds     <= pattern_of(next_state, brake);
      mode_q   <= mode_of(next_state);
      busy     <= (next_state != S_IDLE);
      seq_done <= done_d;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_tail_light_scheduler.sv
// Directed self-checking bench for tail_light_scheduler at TICK_DIV=4.
module tb_tail_light_scheduler;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       left_req = 1'b0, right_req = 1'b0, hazard_req = 1'b0, brake = 1'b0;
  logic [7:0] leds;
  logic [1:0] mode;
  logic       busy, seq_done;

  int vectors = 0;
  int miscompares = 0;
  int done_pulses = 0;

  tail_light_scheduler #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .left_req   (left_req),
    .right_req  (right_req),
    .hazard_req (hazard_req),
    .brake      (brake),
    .leds       (leds),
    .mode       (mode),
    .busy       (busy),
    .seq_done   (seq_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (seq_done === 1'b1) done_pulses++;

  task automatic apply_reset();
    reset = 1'b1;
    {left_req, right_req, hazard_req, brake} = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Bounded wait: returns the number of negedges until leds leaves 'from' (limit on timeout).
  task automatic wait_change(input logic [7:0] from, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (leds === from && n < limit);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors++; if (leds !== 8'h00) begin miscompares++; $display("FAIL reset_leds got %h want 00", leds); end
    vectors++; if (mode !== 2'd0) begin miscompares++; $display("FAIL reset_mode got %0d want 0", mode); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (seq_done !== 1'b0) begin miscompares++; $display("FAIL reset_seq_done got %b want 0", seq_done); end
  endtask

  task automatic test_left_pulse();
    logic [7:0] exp [4] = '{8'h10, 8'h30, 8'h70, 8'hF0};
    int n;
    apply_reset();
    left_req = 1'b1;
    @(negedge clk);
    left_req = 1'b0;
    wait_change(8'h00, 3 * TD, n);
    vectors++; if (n > TD + 1) begin miscompares++; $display("FAIL left_latency got %0d want <=%0d", n, TD + 1); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (leds !== exp[i]) begin miscompares++; $display("FAIL left_step%0d leds got %h want %h", i, leds, exp[i]); end
      vectors++; if (mode !== 2'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL left_step%0d mode/busy got %0d/%b want 1/1", i, mode, busy); end
      wait_change(exp[i], 3 * TD, n);
      vectors++; if (n !== TD) begin miscompares++; $display("FAIL left_hold%0d got %0d want %0d", i, n, TD); end
    end
    vectors++; if (leds !== 8'h00 || seq_done !== 1'b1) begin miscompares++; $display("FAIL left_done leds/seq_done got %h/%b want 00/1", leds, seq_done); end
    vectors++; if (mode !== 2'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL left_done mode/busy got %0d/%b want 0/0", mode, busy); end
    @(negedge clk);
    vectors++; if (seq_done !== 1'b0) begin miscompares++; $display("FAIL left_done_width got %b want 0", seq_done); end
  endtask

  task automatic test_tie();
    logic [7:0] exp [8] = '{8'h10, 8'h30, 8'h70, 8'hF0, 8'h08, 8'h0C, 8'h0E, 8'h0F};
    int n;
    apply_reset();
    {left_req, right_req} = 2'b11;
    @(negedge clk);
    {left_req, right_req} = 2'b00;
    wait_change(8'h00, 3 * TD, n);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        vectors++; if (leds !== 8'h00) begin miscompares++; $display("FAIL tie_gap leds got %h want 00", leds); end
        wait_change(8'h00, 3 * TD, n);
        vectors++; if (n !== TD) begin miscompares++; $display("FAIL tie_gap_len got %0d want %0d", n, TD); end
      end
      vectors++; if (leds !== exp[i]) begin miscompares++; $display("FAIL tie_step%0d leds got %h want %h", i, leds, exp[i]); end
      vectors++; if (mode !== ((i < 4) ? 2'd1 : 2'd2)) begin miscompares++; $display("FAIL tie_step%0d mode got %0d want %0d", i, mode, (i < 4) ? 1 : 2); end
      wait_change(exp[i], 3 * TD, n);
      vectors++; if (n !== TD) begin miscompares++; $display("FAIL tie_hold%0d got %0d want %0d", i, n, TD); end
    end
    vectors++; if (seq_done !== 1'b1) begin miscompares++; $display("FAIL tie_right_done got %b want 1", seq_done); end
    {left_req, right_req} = 2'b11;
    @(negedge clk);
    {left_req, right_req} = 2'b00;
    wait_change(8'h00, 3 * TD, n);
    vectors++; if (leds !== 8'h10) begin miscompares++; $display("FAIL tie_repeat leds got %h want 10", leds); end
  endtask

  task automatic test_hazard_abort();
    int n, done_before;
    apply_reset();
    left_req = 1'b1;
    @(negedge clk);
    left_req = 1'b0;
    wait_change(8'h00, 3 * TD, n);
    wait_change(8'h10, 3 * TD, n);
    vectors++; if (leds !== 8'h30) begin miscompares++; $display("FAIL hz_setup leds got %h want 30", leds); end
    done_before = done_pulses;
    hazard_req = 1'b1;
    wait_change(8'h30, 3 * TD, n);
    vectors++; if (leds !== 8'hFF || n !== TD) begin miscompares++; $display("FAIL hz_on leds/cycles got %h/%0d want ff/%0d", leds, n, TD); end
    vectors++; if (mode !== 2'd3 || busy !== 1'b1) begin miscompares++; $display("FAIL hz_mode mode/busy got %0d/%b want 3/1", mode, busy); end
    wait_change(8'hFF, 3 * TD, n);
    vectors++; if (leds !== 8'h00 || n !== TD) begin miscompares++; $display("FAIL hz_off leds/cycles got %h/%0d want 00/%0d", leds, n, TD); end
    wait_change(8'h00, 3 * TD, n);
    vectors++; if (leds !== 8'hFF || n !== TD) begin miscompares++; $display("FAIL hz_on2 leds/cycles got %h/%0d want ff/%0d", leds, n, TD); end
    hazard_req = 1'b0;
    wait_change(8'hFF, 3 * TD, n);
    vectors++; if (leds !== 8'h00 || mode !== 2'd3) begin miscompares++; $display("FAIL hz_drop_off leds/mode got %h/%0d want 00/3", leds, mode); end
    n = 0;
    do begin @(negedge clk); n++; end while (mode === 2'd3 && n < 3 * TD);
    vectors++; if (n !== TD || mode !== 2'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL hz_idle cycles/mode/busy got %0d/%0d/%b want %0d/0/0", n, mode, busy, TD); end
    vectors++; if (done_pulses !== done_before) begin miscompares++; $display("FAIL hz_no_done got %0d pulses want 0", done_pulses - done_before); end
  endtask

  task automatic test_brake();
    int n;
    apply_reset();
    right_req = 1'b1;
    @(negedge clk);
    right_req = 1'b0;
    wait_change(8'h00, 3 * TD, n);
    wait_change(8'h08, 3 * TD, n);
    wait_change(8'h0C, 3 * TD, n);
    vectors++; if (leds !== 8'h0E) begin miscompares++; $display("FAIL brake_setup leds got %h want 0e", leds); end
    brake = 1'b1;
    @(negedge clk);
    vectors++; if (leds !== 8'hFE || mode !== 2'd2) begin miscompares++; $display("FAIL brake_r3 leds/mode got %h/%0d want fe/2", leds, mode); end
    brake = 1'b0;
    @(negedge clk);
    vectors++; if (leds !== 8'h0E) begin miscompares++; $display("FAIL brake_release leds got %h want 0e", leds); end
    wait_change(8'h0E, 3 * TD, n);
    wait_change(8'h0F, 3 * TD, n);
    brake = 1'b1;
    @(negedge clk);
    vectors++; if (leds !== 8'hFF || mode !== 2'd0) begin miscompares++; $display("FAIL brake_idle leds/mode got %h/%0d want ff/0", leds, mode); end
    brake = 1'b0;
    hazard_req = 1'b1;
    @(negedge clk);
    wait_change(8'h00, 3 * TD, n);
    vectors++; if (leds !== 8'hFF || mode !== 2'd3) begin miscompares++; $display("FAIL brake_hz_on leds/mode got %h/%0d want ff/3", leds, mode); end
    hazard_req = 1'b0;
    wait_change(8'hFF, 3 * TD, n);
    brake = 1'b1;
    @(negedge clk);
    vectors++; if (leds !== 8'h00 || mode !== 2'd3) begin miscompares++; $display("FAIL brake_hz_off leds/mode got %h/%0d want 00/3", leds, mode); end
    wait_change(8'h00, 3 * TD, n);
    vectors++; if (leds !== 8'hFF || mode !== 2'd0) begin miscompares++; $display("FAIL brake_after_hz leds/mode got %h/%0d want ff/0", leds, mode); end
    brake = 1'b0;
  endtask

  task automatic test_reset_mid_sequence();
    int n, bad;
    apply_reset();
    left_req = 1'b1;
    @(negedge clk);
    left_req = 1'b0;
    wait_change(8'h00, 3 * TD, n);
    wait_change(8'h10, 3 * TD, n);
    wait_change(8'h30, 3 * TD, n);
    vectors++; if (leds !== 8'h70) begin miscompares++; $display("FAIL rst_setup leds got %h want 70", leds); end
    right_req = 1'b1;
    @(negedge clk);
    right_req = 1'b0;
    reset = 1'b1;
    #1;
    vectors++; if (leds !== 8'h00 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_async leds/busy got %h/%b want 00/0", leds, busy); end
    vectors++; if (mode !== 2'd0) begin miscompares++; $display("FAIL rst_async_mode got %0d want 0", mode); end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 6 * TD; i++) begin
      @(negedge clk);
      if (leds !== 8'h00 || busy !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rst_no_resume got %0d active cycles want 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4] = '{8'h10, 8'h30, 8'h70, 8'hF0};
    int n;
    apply_reset();
    left_req = 1'b1;
    wait_change(8'h00, 3 * TD, n);
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 4; i++) begin
        vectors++; if (leds !== exp[i]) begin miscompares++; $display("FAIL b2b%0d_step%0d leds got %h want %h", rep, i, leds, exp[i]); end
        wait_change(exp[i], 3 * TD, n);
        vectors++; if (n !== TD) begin miscompares++; $display("FAIL b2b%0d_hold%0d got %0d want %0d", rep, i, n, TD); end
      end
      vectors++; if (leds !== 8'h00) begin miscompares++; $display("FAIL b2b%0d_gap leds got %h want 00", rep, leds); end
      wait_change(8'h00, 3 * TD, n);
      vectors++; if (n !== TD || leds !== 8'h10) begin miscompares++; $display("FAIL b2b%0d_regrant cycles/leds got %0d/%h want %0d/10", rep, n, leds, TD); end
    end
    left_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left_pulse();
    test_tie();
    test_hazard_abort();
    test_brake();
    test_reset_mid_sequence();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tail_light_scheduler.md
# tail_light_scheduler

- Sequences the 8-lamp rear light bank, sharing it among left-turn, right-turn, hazard and brake requests.
- Contains its own step prescaler and a sticky request latch per turn side.
- Arbitrates using priority plus left/right round-robin, and drives the registered LED pattern with a brake overlay.
- Sits between the switch-input conditioning logic and the lamp drivers.

## Interface
- TICK_DIV, 12_500_000: clk cycles per sequence step; 4 Hz at 50 MHz; minimum 2.
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high; clock clk
- left_req  in  1  left-turn request level, synchronous to clk
- right_req  in  1  right-turn request level, synchronous to clk
- hazard_req  in  1  hazard level; sequence runs while high
- brake  in  1  brake level
- leds  out  8  lamp drive; [7:4] left bank, [3:0] right bank
- mode  out  2  active sequence: 0 idle, 1 left, 2 right, 3 hazard
- busy  out  1  high when state is not IDLE
- seq_done  out  1  one-cycle pulse when a turn sequence completes

## Operation
- **Prescaler:**
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - `tick` is high for the one cycle in which the counter equals TICK_DIV-1.
  - The counter free-runs and is independent of state.
- **Pending latches:**
  - pend_l is set in any cycle with left_req=1; pend_r likewise with right_req=1.
  - A grant clears its latch; clear wins over a same-cycle set.
  - Entering HZ_ON clears both latches.
- **States:**
  - IDLE
  - L1..L4: leds[7:4] = 0001, 0011, 0111, 1111
  - R1..R4: leds[3:0] = 1000, 1100, 1110, 1111
  - HZ_ON: 0xFF
  - HZ_OFF: 0x00
- **Transitions:** only on tick. Evaluation order:
  - hazard_req=1 in any state except HZ_ON/HZ_OFF goes to HZ_ON and aborts any turn sequence. No seq_done is issued on abort.
  - HZ_ON goes to HZ_OFF.
  - HZ_OFF goes to HZ_ON if hazard_req=1, else IDLE.
  - IDLE with pend_l and pend_r both set grants the side opposite last_grant. Otherwise IDLE grants whichever latch is set, going to L1 or R1; last_grant takes the granted side.
  - Ln goes to Ln+1; L4 goes to IDLE and pulses seq_done. Rn behaves the same way.
- **Re-request:**
  - A request during a running sequence of the same side stays latched.
  - It is granted on the tick after the return to IDLE, so the lamps are dark for at least one full step between repeats.
- **Brake overlay:**
  - Applies in states other than HZ_ON/HZ_OFF.
  - Any bank not owned by the active turn sequence is forced to 1111.
  - In IDLE, brake gives leds=0xFF.
  - In hazard, brake is ignored.
- **mode:** follows state; busy = (state != IDLE).

## Timing
- **Reset values:**
  - state IDLE, leds 0x00, mode 0, busy 0, seq_done 0
  - prescaler 0, pend_l/pend_r 0, last_grant RIGHT, so left wins the first tie
- leds, mode, busy and seq_done are registered and update on the same edge as the state register.
- leds is recomputed every cycle, so brake reaches leds with 1-cycle latency.
- **Request latency:**
  - The latch sets 1 cycle after req.
  - The pattern appears at the first tick edge after that cycle with state IDLE.
  - Worst case is TICK_DIV+1 cycles from IDLE.
- Each sequence step lasts exactly TICK_DIV cycles.
- A turn sequence occupies 4 ticks; IDLE lasts at least 1 tick before any re-grant.
- seq_done rises on the edge entering IDLE from L4/R4 and lasts 1 cycle.
- Reset asserted mid-sequence forces all reset values immediately; the sequence resumes only on new requests.

## Structure
- **Package tail_light_pkg:**
  - state enumeration (11 states, 4-bit encoding)
  - mode codes
  - LEFT_PAT[1:4] and RIGHT_PAT[1:4] nibble constants
  - bank masks 0xF0/0x0F
- **Sub-module tick_prescaler:**
  - parameter TICK_DIV; counter width $clog2(TICK_DIV)
  - ports clk, reset, tick
- Top holds the pending latches, arbiter, FSM and output register.

## Test plan
All scenarios use TICK_DIV=4.
- **Left pulse:** pulse left_req 1 cycle from IDLE -> leds 0x10, 0x30, 0x70, 0xF0, each held 4 cycles, then 0x00 with seq_done high 1 cycle and mode back to 0.
- **Tie:** left_req and right_req in the same cycle after reset -> left sequence runs first. R1..R4 (0x08, 0x0C, 0x0E, 0x0F) follow after one idle tick. Repeat the tie -> left again, since last_grant is now right.
- **Hazard abort:** hazard_req raised during L2 -> next tick leds=0xFF, then alternating 0xFF/0x00 every 4 cycles, no seq_done. Dropping hazard_req during HZ_ON -> HZ_OFF, then IDLE.
- **Brake:** brake during R3 -> leds=0xFE one cycle later. Brake in IDLE -> 0xFF. Brake in HZ_OFF -> 0x00.
- **Reset:** reset asserted in L3 with pend_r set -> leds=0x00 and busy=0 immediately. After release, no sequence starts without a new request.
- **Re-request:** left_req held continuously -> back-to-back left sequences, each separated by exactly one 4-cycle 0x00 step.
